// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the Wishbone single-transfer master.
// The state encoding is exported so the future bus arbiter can decode it too.
package wb_master_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 64;

  typedef enum logic [1:0] {
    WBM_IDLE    = 2'd0,
    WBM_STROBE  = 2'd1,
    WBM_RECOVER = 2'd2
  } wbm_state_t;

endpackage

// File: rtl/wb_master_if.sv
// Client request/response plus Wishbone master signals, seen from the master
// (master modport) and from everything around it (slave modport).
interface wb_master_if #(
  parameter int ADR_W = wb_master_pkg::WB_ADR_W,
  parameter int DAT_W = wb_master_pkg::WB_DAT_W
);
  // Client handshake: req_i is sampled only while busy_o=0; done_o is a
  // one-cycle pulse and rsp_* stay valid until the next done_o.
  logic             req_i;
  logic             req_we_i;
  logic [ADR_W-1:0] req_adr_i;
  logic [DAT_W-1:0] req_dat_i;
  logic             busy_o;
  logic             done_o;
  logic [DAT_W-1:0] rsp_dat_o;
  logic             rsp_err_o;
  logic             rsp_timeout_o;
  logic [ADR_W-1:0] mst_adr_o;
  logic [DAT_W-1:0] mst_dat_o;
  logic [DAT_W-1:0] mst_dat_i;
  logic             mst_we_o;
  logic             mst_stb_o;
  logic             mst_cyc_o;
  logic             mst_ack_i;
  logic             mst_err_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_dat_i, mst_dat_i, mst_ack_i, mst_err_i,
    output busy_o, done_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           mst_adr_o, mst_dat_o, mst_we_o, mst_stb_o, mst_cyc_o
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_dat_i, mst_dat_i, mst_ack_i, mst_err_i,
    input  busy_o, done_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           mst_adr_o, mst_dat_o, mst_we_o, mst_stb_o, mst_cyc_o
  );
endinterface

// File: rtl/wb_master_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one. TIMEOUT=0 disables it.
module wb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit ACTIVE = (TIMEOUT > 0);

  logic [CW-1:0] count;

  // Saturates at LAST so a stalled enable cannot wrap into a false expiry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ACTIVE && enable && (count == LAST);
endmodule

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator with strobe-low recovery and a
// watchdog abort for transfers no slave answers.
module wb_master
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_master_if.master  bus,
  output wbm_state_t   state
);
  logic wd_expired;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (state != WBM_STROBE),
    .enable  (state == WBM_STROBE),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= WBM_IDLE;
      bus.busy_o        <= 1'b0;
      bus.done_o        <= 1'b0;
      bus.rsp_dat_o     <= '0;
      bus.rsp_err_o     <= 1'b0;
      bus.rsp_timeout_o <= 1'b0;
      bus.mst_adr_o     <= '0;
      bus.mst_dat_o     <= '0;
      bus.mst_we_o      <= 1'b0;
      bus.mst_stb_o     <= 1'b0;
      bus.mst_cyc_o     <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        WBM_IDLE: begin
          if (bus.req_i) begin
            bus.mst_adr_o <= bus.req_adr_i;
            bus.mst_dat_o <= bus.req_dat_i;
            bus.mst_we_o  <= bus.req_we_i;
            bus.mst_stb_o <= 1'b1;
            bus.mst_cyc_o <= 1'b1;
            bus.busy_o    <= 1'b1;
            state         <= WBM_STROBE;
          end
        end
        WBM_STROBE: begin
          // err outranks ack; the watchdog only fires when neither arrived.
          if (bus.mst_err_i || bus.mst_ack_i || wd_expired) begin
            bus.mst_stb_o     <= 1'b0;
            bus.mst_cyc_o     <= 1'b0;
            bus.mst_we_o      <= 1'b0;
            bus.done_o        <= 1'b1;
            bus.rsp_err_o     <= bus.mst_err_i || !bus.mst_ack_i;
            bus.rsp_timeout_o <= !bus.mst_err_i && !bus.mst_ack_i;
            if (bus.mst_ack_i && !bus.mst_err_i && !bus.mst_we_o) begin
              bus.rsp_dat_o <= bus.mst_dat_i;
            end
            state <= WBM_RECOVER;
          end
        end
        WBM_RECOVER: begin
          // Wait until the slave has dropped its held ack/err after seeing stb low.
          if (!bus.mst_ack_i && !bus.mst_err_i) begin
            bus.busy_o <= 1'b0;
            state      <= WBM_IDLE;
          end
        end
        default: state <= WBM_IDLE;
      endcase
    end
  end
endmodule
